// File: rtl/clk_ratio_monitor.sv
// Measures the period of a clk-synchronous divided clock and checks it against a programmed ratio.
// Optional high-time (duty) check is compiled in with `define CLK_RATIO_MON_DUTY_CHECK_EN.
module clk_ratio_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] expect_div,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout,
  output logic             cfg_err,
  output logic [ERR_W-1:0] err_cnt
`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    MEASURE,
    LOCKED
  } state_t;

  state_t           state;
  logic             div_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] exp_r;
  logic [MW-1:0]    match_cnt;

  logic             rise;
  logic             cnt_sat;
  logic             active;
  logic [CNT_W:0]   exp2;
  logic             to_evt;
  logic             rep_evt;
  logic             mis_evt;
  logic             duty_evt;
  logic             bad_evt;
  logic             err_evt;
  logic             match_evt;

  assign rise    = div_in & ~div_d;
  assign cnt_sat = &cnt;
  assign active  = enable && ((state == MEASURE) || (state == LOCKED));
  // Doubled expectation kept one bit wider so large ratios cannot wrap
  assign exp2    = {exp_r, 1'b0};

  assign to_evt    = active && !rise && (({1'b0, cnt} >= exp2) || cnt_sat);
  assign rep_evt   = active && rise;
  assign mis_evt   = rep_evt && (cnt != exp_r);
  assign bad_evt   = mis_evt || duty_evt;
  assign err_evt   = to_evt || bad_evt;
  assign match_evt = rep_evt && !bad_evt;

`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] duty_lo;
  logic [CNT_W-1:0] duty_hi;
  logic             fall;

  assign fall     = ~div_in & div_d;
  assign duty_lo  = exp_r >> 1;
  assign duty_hi  = duty_lo + CNT_W'(exp_r[0]);
  assign duty_evt = active && fall && (hcnt != duty_lo) && (hcnt != duty_hi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt     <= '0;
      duty_err <= 1'b0;
    end else begin
      duty_err <= duty_evt;
      if (rise)
        hcnt <= CNT_W'(1);
      else if (div_in && !(&hcnt))
        hcnt <= hcnt + CNT_W'(1);
    end
  end
`else
  assign duty_evt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      div_d        <= 1'b0;
      cnt          <= '0;
      exp_r        <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      timeout      <= 1'b0;
      cfg_err      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      div_d        <= div_in;
      cnt          <= rise ? CNT_W'(1) : (cnt_sat ? cnt : cnt + CNT_W'(1));
      period_valid <= rep_evt;
      err          <= err_evt;
      timeout      <= to_evt;
      if (rep_evt)
        period <= cnt;

      // A clear wins over history but still counts an error landing in the same cycle
      if (clr)
        err_cnt <= err_evt ? ERR_W'(1) : '0;
      else if (err_evt && !(&err_cnt))
        err_cnt <= err_cnt + ERR_W'(1);

      case (state)
        IDLE: begin
          exp_r   <= expect_div;
          cfg_err <= (exp_r < CNT_W'(2));
          if (enable && (exp_r >= CNT_W'(2))) begin
            state   <= ALIGN;
            cfg_err <= 1'b0;
          end
        end
        ALIGN: begin
          if (rise) begin
            state     <= MEASURE;
            match_cnt <= '0;
          end
        end
        MEASURE, LOCKED: begin
          if (to_evt) begin
            locked    <= 1'b0;
            match_cnt <= '0;
            state     <= ALIGN;
          end else if (bad_evt) begin
            locked    <= 1'b0;
            match_cnt <= '0;
            state     <= MEASURE;
          end else if (match_evt && (state == MEASURE)) begin
            match_cnt <= match_cnt + MW'(1);
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (!enable) begin
        state     <= IDLE;
        locked    <= 1'b0;
        match_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor: expected reports are queued with each stimulus period
// and popped by an independent monitor whenever the DUT reports a period, error or timeout.
module tb_clk_ratio_monitor;

  localparam int CNT_W = 8;
  localparam int ERR_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             div_in = 1'b0;
  logic [CNT_W-1:0] expect_div = '0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic             timeout;
  logic             cfg_err;
  logic [ERR_W-1:0] err_cnt;
`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
  logic             duty_err;
`endif

  clk_ratio_monitor #(
    .CNT_W(CNT_W),
    .LOCK_CNT(4),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .div_in(div_in),
    .expect_div(expect_div),
    .clr(clr),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .err(err),
    .timeout(timeout),
    .cfg_err(cfg_err),
    .err_cnt(err_cnt)
`ifdef CLK_RATIO_MON_DUTY_CHECK_EN
    ,
    .duty_err(duty_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [7:0] per;
    logic       er;
    logic       to;
    logic       lk;
  } evt_t;

  evt_t exp_q[$];
  int   tests = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // One divided-clock period starting with its rising edge; the expectation describes the
  // report produced at that rising edge, i.e. the length of the previous period.
  task automatic applyStimulus(input int hi, input int lo, input bit ev, input int per,
                               input bit er, input bit lk, input bit with_clr = 1'b0);
    evt_t e;
    if (ev) begin
      e.pv  = 1'b1;
      e.per = 8'(per);
      e.er  = er;
      e.to  = 1'b0;
      e.lk  = lk;
      exp_q.push_back(e);
    end
    div_in = 1'b1;
    clr    = with_clr;
    tick();
    clr = 1'b0;
    repeat (hi - 1) tick();
    div_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_period"}, period, 0);
    checkOutput({tag, "_period_valid"}, period_valid, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
    checkOutput({tag, "_cfg_err"}, cfg_err, 0);
    checkOutput({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  always @(negedge clk) begin
    evt_t e;
    if (rst && (period_valid || err || timeout)) begin
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_event: pv=%0b period=%0d err=%0b timeout=%0b, required no event",
                 period_valid, period, err, timeout);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ev_period_valid", period_valid, e.pv);
        checkOutput("ev_period", period, e.per);
        checkOutput("ev_err", err, e.er);
        checkOutput("ev_timeout", timeout, e.to);
        checkOutput("ev_locked", locked, e.lk);
      end
    end
  end

  initial begin
    evt_t t;
    expect_div = 8'd2;
    #1 rst = 1'b0;
    #6 checkAllZero("reset");
    #5 rst = 1'b1;
    repeat (3) tick();

    // Divide-by-2
    enable = 1'b1;
    repeat (2) tick();
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1, 1, 1, 2, 0, i == 4);
    applyStimulus(1, 1, 1, 2, 0, 1);
    checkOutput("div2_locked", locked, 1);
    enable = 1'b0;
    tick();
    checkOutput("div2_unlock", locked, 0);
    checkOutput("div2_err_cnt", err_cnt, 0);

    // Divide-by-6, then the same clock against a wrong ratio
    expect_div = 8'd6;
    repeat (2) tick();
    enable = 1'b1;
    repeat (2) tick();
    applyStimulus(3, 3, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(3, 3, 1, 6, 0, i == 4);
    applyStimulus(3, 3, 1, 6, 0, 1);
    checkOutput("div6_locked", locked, 1);
    enable = 1'b0;
    tick();
    expect_div = 8'd4;
    repeat (2) tick();
    enable = 1'b1;
    repeat (2) tick();
    applyStimulus(3, 3, 0, 0, 0, 0);
    applyStimulus(3, 3, 1, 6, 1, 0);
    applyStimulus(3, 3, 1, 6, 1, 0);
    checkOutput("mis_locked", locked, 0);
    enable = 1'b0;
    tick();
    checkOutput("mis_err_cnt", err_cnt, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clr_err_cnt", err_cnt, 0);

    // Glitch while locked, then relock
    enable = 1'b1;
    repeat (2) tick();
    applyStimulus(2, 2, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(2, 2, 1, 4, 0, i == 4);
    applyStimulus(3, 2, 1, 4, 0, 1);
    applyStimulus(2, 2, 1, 5, 1, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(2, 2, 1, 4, 0, i == 4);
    checkOutput("glitch_relocked", locked, 1);
    checkOutput("glitch_err_cnt", err_cnt, 1);

    // Stuck low: last rise was 4 cycles ago, timeout lands on the 8th cycle
    repeat (4) tick();
    t.pv  = 1'b0;
    t.per = 8'd4;
    t.er  = 1'b1;
    t.to  = 1'b1;
    t.lk  = 1'b0;
    exp_q.push_back(t);
    tick();
    checkOutput("stuck_locked", locked, 0);
    checkOutput("stuck_err_cnt", err_cnt, 2);
    applyStimulus(2, 2, 0, 0, 0, 0);
    enable = 1'b0;
    tick();

    // Bad configuration never leaves IDLE
    expect_div = 8'd1;
    repeat (3) tick();
    enable = 1'b1;
    repeat (3) tick();
    checkOutput("cfg_err_set", cfg_err, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("cfg_err_held", cfg_err, 1);
    checkOutput("cfg_locked", locked, 0);
    enable = 1'b0;
    expect_div = 8'd4;
    repeat (2) tick();
    checkOutput("cfg_err_clear", cfg_err, 0);

    // Enable dropped while locked
    enable = 1'b1;
    repeat (2) tick();
    applyStimulus(2, 2, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(2, 2, 1, 4, 0, i == 4);
    checkOutput("en_locked", locked, 1);
    enable = 1'b0;
    tick();
    checkOutput("en_unlock", locked, 0);
    checkOutput("en_err_cnt", err_cnt, 2);

    // Asynchronous reset mid-measure
    enable = 1'b1;
    repeat (2) tick();
    applyStimulus(2, 2, 0, 0, 0, 0);
    applyStimulus(2, 2, 1, 4, 0, 0);
    #3 rst = 1'b0;
    #1 checkAllZero("async_rst");
    enable = 1'b0;
    #3 rst = 1'b1;
    repeat (3) tick();

    // Error counter saturation and clear coincident with an error
    enable = 1'b1;
    repeat (2) tick();
    applyStimulus(3, 3, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(3, 3, 1, 6, 1, 0);
    checkOutput("sat_err_cnt", err_cnt, 3);
    applyStimulus(3, 3, 1, 6, 1, 0, 1'b1);
    checkOutput("clr_with_err_cnt", err_cnt, 1);
    enable = 1'b0;
    repeat (3) tick();

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/clk_ratio_monitor.md
Name: clk_ratio_monitor

Overview:
- Receive-side companion to the team's clock dividers.
- Samples one divided-clock signal, generated by registers in the `clk` domain, as synchronous data.
- Measures its period in `clk` cycles and checks it against a runtime-programmed ratio.
- Reports lock, mismatch errors and stuck-clock timeouts, so divider outputs (÷2, ÷4, ÷6, …) can be verified in-system.

Parameters:
- CNT_W, 8, width of the period counter and of `expect_div`/`period`; maximum measurable period 2^CNT_W-1.
- LOCK_CNT, 4, number of consecutive matching periods required to assert `locked`.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  monitor enable; low forces IDLE.
- div_in  input  1  divided clock under test, synchronous to `clk`.
- expect_div  input  CNT_W  expected period in `clk` cycles; sampled only while in IDLE.
- clr  input  1  synchronous clear of `err_cnt`.
- period  output  CNT_W  last measured period.
- period_valid  output  1  one-cycle pulse when `period` updates.
- locked  output  1  ratio confirmed.
- err  output  1  one-cycle pulse on period mismatch or timeout.
- timeout  output  1  one-cycle pulse when no rising edge is seen within 2*exp cycles.
- cfg_err  output  1  level; `exp` < 2.
- err_cnt  output  ERR_W  saturating count of `err` pulses.

Behaviour:
- Reset (rst=0): all outputs 0, state IDLE, internal counters 0, `div_d` 0.
- `div_d` is the registered `div_in`; rise = `div_in` & ~`div_d`.
- `cnt`: loads 1 on rise, otherwise increments; saturates at 2^CNT_W-1.
- `exp` register: captured from `expect_div` every cycle while in IDLE; held constant outside IDLE.
- States:
  - IDLE: if `enable`=1 and `exp`>=2, go to ALIGN. If `exp`<2, `cfg_err`=1 and stay in IDLE.
  - ALIGN: wait for the first rise (load `cnt`=1, go to MEASURE); no period reported.
  - MEASURE: on rise, `period`<=`cnt` and `period_valid` pulses (registered, 1-cycle latency after the rise cycle).
    - Match (`cnt`==`exp`): increment `match_cnt`; reaching LOCK_CNT goes to LOCKED with `locked`=1 the same cycle.
    - Mismatch: `err` pulses, `match_cnt`<=0, stay in MEASURE.
  - LOCKED: on rise, report the period as in MEASURE. Mismatch → `err` pulse, `locked`<=0, `match_cnt`<=0, go to MEASURE.
- Timeout (MEASURE or LOCKED): `cnt` reaches 2*`exp` with no rise, or `cnt` saturates, whichever comes first.
  - `timeout` and `err` pulse, `locked`<=0, go to ALIGN.
  - Compare is done at CNT_W+1 bits; no wrap.
- `enable` low in any state: IDLE next cycle, `locked`<=0, `match_cnt`<=0; `err_cnt` retained.
- `err_cnt`: +1 per `err` pulse, saturates at all-ones.
  - `clr` alone → 0.
  - `clr` and `err` in the same cycle → 1.
- Rise in the same cycle `enable` drops: ignored.
- `div_in` stuck high or low: handled identically by timeout.
- Changing `expect_div` outside IDLE: no effect until the next pass through IDLE.

Optional Feature:
- Macro: CLK_RATIO_MON_DUTY_CHECK_EN.
- Defined:
  - Add a high-time counter `hcnt`: loads 1 on rise, increments while `div_in`=1.
  - On fall, check `hcnt` against floor(`exp`/2) or ceil(`exp`/2); odd ratios accept either.
  - Failure: extra output `duty_err` (1-bit, one-cycle pulse) plus an `err` pulse, same consequences as a period mismatch. A period mismatch and duty failure on the same cycle count once.
- Undefined: no `hcnt`, no `duty_err` port, no duty checking.

Test Plan:
- Lock at ÷2: `exp`=2, `div_in` toggling every cycle, `enable`=1 → `period_valid` every 2 cycles with `period`=2; `locked`=1 after the 4th matching rise; `err_cnt`=0.
- Lock at ÷6 (toggle every 3 cycles): `exp`=6 → `period`=6 repeatedly, `locked`=1. Then `exp`=4 with the same `div_in` in a separate run → `err` on every rise, `locked` never asserts, `err_cnt` increments per rise.
- Glitch while locked: `exp`=4, locked, one period of 5 injected → single `err` pulse, `locked` drops, re-locks after 4 good periods; `err_cnt`=1.
- Stuck clock: `exp`=4, locked, `div_in` held 0 → `timeout`+`err` exactly 8 cycles after the last rise; state ALIGN; `locked`=0.
- Config/enable: `exp`=1 → `cfg_err`=1, never leaves IDLE. Then `exp`=4, `enable` dropped mid-lock → `locked`=0 next cycle, `err_cnt` unchanged. Async `rst` pulse mid-MEASURE → all outputs 0 immediately.
- Counter saturation/clear (ERR_W=2): 5 errors → `err_cnt`=3; `clr` coincident with `err` → `err_cnt`=1.
